soc_system_led_pwm: RTL

SOC_SYSTEM_LED_PWM -- requirements
Module: soc_system_led_pwm

---
 rtl/soc_system_led_pwm.sv | 69 ++++++
 1 files changed

// File: rtl/soc_system_led_pwm.sv
// soc_system_led_pwm: Avalon-MM PWM dimmer and blinker gating the LED PIO pattern onto the physical LEDs
module soc_system_led_pwm #(
  parameter int unsigned PRESCALE = 195
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  led_in,
  output logic [9:0]  led_out
);
  logic [1:0]  ctrl_q, ctrl_d;
  logic [8:0]  duty_pend_q, duty_pend_d, duty_act_q, duty_act_d;
  logic [15:0] half_q, half_d, presc_q, presc_d, blink_cnt_q, blink_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        phase_q, phase_d;
  logic [9:0]  led_q, led_d;
  logic        wr, half_wr, tick, bnd, blink_wrap, pwm_on, unused_w;
  assign unused_w = ^writedata[31:16];
  always_comb begin
    wr          = chipselect & ~write_n;
    half_wr     = wr && address == 2'd2;
    tick        = presc_q == 16'(PRESCALE - 1);
    bnd         = tick && pwm_cnt_q == 8'hFF;
    blink_wrap  = bnd && blink_cnt_q == half_q - 16'd1;
    pwm_on      = {1'b0, pwm_cnt_q} < duty_act_q;
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d   = pwm_cnt_q + 8'(tick);
    ctrl_d      = wr && address == 2'd0 ? writedata[1:0] : ctrl_q;
    duty_pend_d = wr && address == 2'd1 ? (writedata[15:0] > 16'd256 ? 9'd256 : writedata[8:0]) : duty_pend_q;
    duty_act_d  = bnd ? duty_pend_q : duty_act_q;
    half_d      = half_wr ? writedata[15:0] : half_q;
    blink_cnt_d = half_wr || half_q == 16'd0 || blink_wrap ? 16'd0 : blink_cnt_q + 16'(bnd);
    phase_d     = half_wr || half_q == 16'd0 ? 1'b1 : phase_q ^ blink_wrap;
    led_d       = led_in & {10{ctrl_q[0] & pwm_on & (~ctrl_q[1] | phase_q)}};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= 2'b01;
      duty_pend_q <= 9'd256;
      duty_act_q  <= 9'd256;
      half_q      <= 16'd0;
      presc_q     <= 16'd0;
      blink_cnt_q <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      phase_q     <= 1'b1;
      led_q       <= 10'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      half_q      <= half_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end
  assign led_out = led_q;
  always_comb
    readdata = address == 2'd0 ? {30'd0, ctrl_q} :
               address == 2'd1 ? {23'd0, duty_pend_q} :
               address == 2'd2 ? {16'd0, half_q} :
                                 {pwm_cnt_q, 6'd0, led_q, 7'd0, phase_q};
endmodule
